// File: rtl/reflow_clk_pkg.sv
// Shared clocking/reset definitions for the 8052 SOC clock tree:
// sequencer state encodings, 50 MHz default cycle counts and width helpers.
package reflow_clk_pkg;

    // seq_state encodings; 5-7 are never produced and recover to S_PLL_RST.
    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } seq_state_t;

    // Defaults for a 50 MHz refclk.
    localparam int DEF_POR_CYCLES    = 1000;    // 20 us PLL reset pulse
    localparam int DEF_LOCK_TIMEOUT  = 500000;  // 10 ms lock window
    localparam int DEF_STABLE_CYCLES = 1024;    // lock must hold this long
    localparam int DEF_RETRY_MAX     = 3;
    localparam int DEF_LL_W          = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL / core reset tree.
// There is no valid/ready handshake on this bundle: every signal is a level.
// pll_locked is asynchronous to refclk; all other signals are registered on
// refclk by the sequencer and may be sampled on any refclk edge.
interface pll_reset_sequencer_if #(
    parameter int LL_W = 8
);
    logic            pll_locked;
    logic            pll_rst;
    logic            sys_rst_n;
    logic            pll_fault;
    logic [2:0]      seq_state;
    logic [LL_W-1:0] lock_loss_cnt;

    // Sequencer side.
    modport master (
        input  pll_locked,
        output pll_rst,
        output sys_rst_n,
        output pll_fault,
        output seq_state,
        output lock_loss_cnt
    );

    // PLL / reset-tree side.
    modport slave (
        output pll_locked,
        input  pll_rst,
        input  sys_rst_n,
        input  pll_fault,
        input  seq_state,
        input  lock_loss_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for slow asynchronous levels; resets to all zeros.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    // Two back-to-back flops; only the second is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with timeout and
// retry limit, demands a stable lock window, then releases the 8052 system
// reset. Loss of lock while running re-sequences the PLL and is counted.
module pll_reset_sequencer
    import reflow_clk_pkg::*;
#(
    parameter int POR_CYCLES    = DEF_POR_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int RETRY_MAX     = DEF_RETRY_MAX,
    parameter int LL_W          = DEF_LL_W   // must match the interface LL_W
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    pll_reset_sequencer_if.master bus
);
    localparam int CNT_W   = cnt_width(max3(POR_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
    localparam int RETRY_W = cnt_width(RETRY_MAX + 1);

    localparam logic [CNT_W-1:0]   POR_LAST     = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_TOP    = RETRY_W'(RETRY_MAX);

    seq_state_t        state;
    seq_state_t        state_next;
    logic [CNT_W-1:0]  cnt;
    logic [RETRY_W-1:0] retry;
    logic [RETRY_W-1:0] retry_next;
    logic [LL_W-1:0]   loss_cnt;
    logic              loss_event;
    logic              attempt_fail;
    logic              locked_s;

    logic pll_rst_q,   pll_rst_d;
    logic sys_rst_n_q, sys_rst_n_d;
    logic fault_q,     fault_d;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (bus.pll_locked),
        .q     (locked_s)
    );

    // State register plus the output flops, which load the decode of the
    // next state so outputs change on the same edge as seq_state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_PLL_RST;
            retry       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state       <= state_next;
            retry       <= retry_next;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            fault_q     <= fault_d;
        end
    end

    // Next-state logic; a failed attempt is resolved against the retry budget.
    always_comb begin
        state_next   = state;
        retry_next   = retry;
        loss_event   = 1'b0;
        attempt_fail = 1'b0;
        case (state)
            S_PLL_RST: begin
                if (cnt == POR_LAST) state_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s)                  state_next   = S_STABLE;
                else if (cnt == TIMEOUT_LAST)  attempt_fail = 1'b1;
            end
            S_STABLE: begin
                if (!locked_s) begin
                    attempt_fail = 1'b1;
                end else if (cnt == STABLE_LAST) begin
                    state_next = S_RUN;
                    retry_next = '0;
                end
            end
            S_RUN: begin
                // Loss of lock re-sequences without spending a retry.
                if (!locked_s) begin
                    state_next = S_PLL_RST;
                    loss_event = 1'b1;
                end
            end
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_PLL_RST;
        endcase
        if (attempt_fail) begin
            if (retry == RETRY_TOP) begin
                state_next = S_FAULT;
            end else begin
                retry_next = retry + 1'b1;
                state_next = S_PLL_RST;
            end
        end
    end

    // Output decode from the next state; pll_fault is sticky until rst_n.
    always_comb begin
        pll_rst_d   = (state_next == S_PLL_RST) || (state_next == S_FAULT);
        sys_rst_n_d = (state_next == S_RUN);
        fault_d     = fault_q || (state_next == S_FAULT);
    end

    // Phase timer: cleared on every state change, idle in RUN and FAULT.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= '0;
        end else if (state == S_PLL_RST || state == S_WAIT_LOCK || state == S_STABLE) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Saturating count of RUN -> PLL_RST transitions.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt <= '0;
        end else if (loss_event && (loss_cnt != {LL_W{1'b1}})) begin
            loss_cnt <= loss_cnt + 1'b1;
        end
    end

    assign bus.pll_rst       = pll_rst_q;
    assign bus.sys_rst_n     = sys_rst_n_q;
    assign bus.pll_fault     = fault_q;
    assign bus.seq_state     = state;
    assign bus.lock_loss_cnt = loss_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random lock
// patterns, checked cycle by cycle against a phase/duration model.
module tb_pll_reset_sequencer;

    localparam int POR   = 8;
    localparam int TO    = 32;
    localparam int STB   = 16;
    localparam int RMAX  = 2;
    localparam int LLW   = 8;
    localparam int OUT_W = LLW + 6;
    localparam int LOSS_SAT = (1 << LLW) - 1;

    // ---------------- clock / reset ----------------
    logic refclk;
    logic rst_n;
    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    pll_reset_sequencer_if #(.LL_W(LLW)) bus ();

    pll_reset_sequencer #(
        .POR_CYCLES    (POR),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (STB),
        .RETRY_MAX     (RMAX),
        .LL_W          (LLW)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    // ---------------- reference model ----------------
    // The model thinks in phases with durations: hold the PLL in reset for
    // POR cycles, give it TO cycles to lock, demand STB locked cycles, run.
    typedef enum int {M_HOLD, M_WAIT, M_STAB, M_RUN, M_FAULT} mphase_t;

    mphase_t m_phase;
    int      m_el;
    int      m_fails;
    int      m_losses;
    bit      m_d1, m_d2;   // pll_locked as seen one and two edges ago

    logic [OUT_W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [OUT_W-1:0] pack_out(input bit prst, input bit srn, input bit flt,
                                                  input int code, input int loss);
        logic [2:0]     c;
        logic [LLW-1:0] l;
        c = 3'(code);
        l = LLW'(loss);
        return {prst, srn, flt, c, l};
    endfunction

    function automatic logic [OUT_W-1:0] exp_outputs();
        int code;
        case (m_phase)
            M_HOLD:  code = 0;
            M_WAIT:  code = 1;
            M_STAB:  code = 2;
            M_RUN:   code = 3;
            default: code = 4;
        endcase
        return pack_out(m_phase == M_HOLD || m_phase == M_FAULT, m_phase == M_RUN,
                        m_phase == M_FAULT, code, m_losses);
    endfunction

    task automatic model_reset();
        m_phase = M_HOLD; m_el = 0; m_fails = 0; m_losses = 0;
        m_d1 = 1'b0; m_d2 = 1'b0;
    endtask

    task automatic enter(input mphase_t p);
        m_phase = p;
        m_el = 0;
    endtask

    task automatic fail_attempt();
        if (m_fails == RMAX) begin
            enter(M_FAULT);
        end else begin
            m_fails++;
            enter(M_HOLD);
        end
    endtask

    task automatic model_step();
        bit ls;
        ls   = m_d2;
        m_d2 = m_d1;
        m_d1 = bus.pll_locked;
        case (m_phase)
            M_HOLD: if (m_el + 1 == POR) enter(M_WAIT); else m_el++;
            M_WAIT: begin
                if (ls)                  enter(M_STAB);
                else if (m_el + 1 == TO) fail_attempt();
                else                     m_el++;
            end
            M_STAB: begin
                if (!ls) fail_attempt();
                else if (m_el + 1 == STB) begin
                    enter(M_RUN);
                    m_fails = 0;
                end else m_el++;
            end
            M_RUN: begin
                if (!ls) begin
                    enter(M_HOLD);
                    if (m_losses < LOSS_SAT) m_losses++;
                end
            end
            default: ;
        endcase
    endtask

    // Model advances on each edge; a reset flushes anything still pending.
    initial begin
        model_reset();
        forever begin
            @(posedge refclk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
                exp_q.delete();
            end else begin
                model_step();
            end
            exp_q.push_back(exp_outputs());
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: actual pll_rst=%0b sys_rst_n=%0b pll_fault=%0b seq_state=%0d lock_loss_cnt=%0d / required pll_rst=%0b sys_rst_n=%0b pll_fault=%0b seq_state=%0d lock_loss_cnt=%0d",
                     name, $time, act[LLW+5], act[LLW+4], act[LLW+3], act[LLW+2:LLW], act[LLW-1:0],
                     exp[LLW+5], exp[LLW+4], exp[LLW+3], exp[LLW+2:LLW], exp[LLW-1:0]);
        end
    endtask

    function automatic logic [OUT_W-1:0] dut_out();
        return {bus.pll_rst, bus.sys_rst_n, bus.pll_fault, bus.seq_state, bus.lock_loss_cnt};
    endfunction

    // Monitor: every falling edge the DUT presents one registered output set.
    initial begin
        logic [OUT_W-1:0] exp;
        forever begin
            @(negedge refclk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check("cycle_out", dut_out(), exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_cycles(input bit lk, input int n);
        repeat (n) begin
            @(negedge refclk);
            bus.pll_locked = lk;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge refclk);
        rst_n = 1'b0;
        repeat (n) @(negedge refclk);
        rst_n = 1'b1;
    endtask

    // rst_n dropped mid-cycle for one cycle; outputs must react without a clock.
    task automatic pulse_reset_async();
        @(posedge refclk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_out(), pack_out(1'b1, 1'b0, 1'b0, 0, 0));
        @(negedge refclk);
        @(negedge refclk);
        rst_n = 1'b1;
    endtask

    task automatic wait_phase(input mphase_t p, input int budget, input string name);
        int k;
        k = 0;
        while (m_phase != p && k < budget) begin
            @(negedge refclk);
            k++;
        end
        if (m_phase != p) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: phase %0d not reached within %0d cycles (now %0d)", name, p, budget, m_phase);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        bus.pll_locked = 1'b1;
        repeat (3) @(negedge refclk);

        // Lock present from the start: straight through to RUN.
        rst_n = 1'b1;
        drive_cycles(1'b1, 40);
        check("case1_run", dut_out(), pack_out(1'b0, 1'b1, 1'b0, 3, 0));

        // No lock ever: three timed-out attempts, then FAULT for good.
        bus.pll_locked = 1'b0;
        do_reset(2);
        drive_cycles(1'b0, 130);
        check("case2_fault", dut_out(), pack_out(1'b1, 1'b0, 1'b1, 4, 0));
        drive_cycles(1'b0, 1000);
        check("case2_fault_hold", dut_out(), pack_out(1'b1, 1'b0, 1'b1, 4, 0));

        // Reset out of FAULT, then lock again.
        pulse_reset_async();
        drive_cycles(1'b1, 40);

        // Three-cycle lock loss in RUN.
        drive_cycles(1'b0, 3);
        drive_cycles(1'b1, 40);
        check("case3_relock", dut_out(), pack_out(1'b0, 1'b1, 1'b0, 3, 1));

        // Reset out of RUN, then two glitched STABLE windows.
        pulse_reset_async();
        drive_cycles(1'b1, 1);
        for (int a = 0; a < 2; a++) begin
            wait_phase(M_STAB, 100, "case4_stable");
            drive_cycles(1'b1, 3);
            drive_cycles(1'b0, 2);
            drive_cycles(1'b1, 1);
            wait_phase(M_HOLD, 20, "case4_retry");
        end
        wait_phase(M_RUN, 100, "case4_run");
        drive_cycles(1'b0, 200);
        check("case4_fault", dut_out(), pack_out(1'b1, 1'b0, 1'b1, 4, 1));

        // 260 loss-of-lock events: counter saturates.
        bus.pll_locked = 1'b1;
        do_reset(2);
        wait_phase(M_RUN, 100, "case6_first_run");
        for (int e = 0; e < 260; e++) begin
            drive_cycles(1'b0, 1);
            drive_cycles(1'b1, 1);
            wait_phase(M_HOLD, 10, "case6_loss");
            wait_phase(M_RUN, 100, "case6_run");
        end
        drive_cycles(1'b1, 5);
        check("case6_saturate", dut_out(), pack_out(1'b0, 1'b1, 1'b0, 3, LOSS_SAT));

        // Random lock/unlock segments with occasional resets.
        for (int s = 0; s < 200; s++) begin
            drive_cycles(1'($urandom_range(0, 1)), $urandom_range(1, 45));
            if ($urandom_range(0, 19) == 0) pulse_reset_async();
        end

        repeat (3) @(negedge refclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog.
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
